// File: rtl/mips_shift_pkg.sv
// Shared definitions for the multi-cycle MIPS shifters: FSM encoding,
// default widths and the fast-mode step size.
package mips_shift_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SHAMT_WIDTH_DEF = 5;
  localparam int FAST_STEP       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/result bundle between the control unit and the right shifter.
interface shift_right_seq_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start_i;
  logic                   arith_i;
  logic [DATA_WIDTH-1:0]  data_i;
  logic [SHAMT_WIDTH-1:0] shamt_i;
  logic                   busy_o;
  logic                   done_o;
  logic [DATA_WIDTH-1:0]  data_o;

  modport master (
    output start_i, arith_i, data_i, shamt_i,
    input  busy_o, done_o, data_o
  );

  modport slave (
    input  start_i, arith_i, data_i, shamt_i,
    output busy_o, done_o, data_o
  );
endinterface

// File: rtl/shift_right_step.sv
// One combinational right-shift step by 1 or FAST_STEP positions; the fill
// bit is the current MSB in arithmetic mode and zero otherwise.
module shift_right_step
  import mips_shift_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_mode,
  input  logic [2:0]            i_step,
  output logic [DATA_WIDTH-1:0] o_value
);

  logic w_fill;

  assign w_fill = i_mode & i_value[DATA_WIDTH-1];

  always_comb begin
    if (i_step == 3'(FAST_STEP)) begin
      o_value = {{FAST_STEP{w_fill}}, i_value[DATA_WIDTH-1:FAST_STEP]};
    end else begin
      o_value = {w_fill, i_value[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA/SRLV/SRAV) with start/busy/done handshake.
// Define SHIFT_RIGHT_FAST4_EN to take 4-bit steps while the count allows it.
module shift_right_seq
  import mips_shift_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  shift_right_seq_if.slave   bus
);

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_work;
  logic [SHAMT_WIDTH-1:0] r_count;
  logic                   r_mode;
  logic                   r_busy;
  logic                   r_done;
  logic [DATA_WIDTH-1:0]  r_data;

  logic                   w_use4;
  logic [2:0]             w_step;
  logic [SHAMT_WIDTH-1:0] w_dec;
  logic [DATA_WIDTH-1:0]  w_next;

`ifdef SHIFT_RIGHT_FAST4_EN
  assign w_use4 = (r_count >= SHAMT_WIDTH'(FAST_STEP));
`else
  assign w_use4 = 1'b0;
`endif

  // The decrement always matches the step taken, so the count lands exactly on zero.
  assign w_step = w_use4 ? 3'(FAST_STEP) : 3'd1;
  assign w_dec  = w_use4 ? SHAMT_WIDTH'(FAST_STEP) : SHAMT_WIDTH'(1);

  shift_right_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_value (r_work),
    .i_mode  (r_mode),
    .i_step  (w_step),
    .o_value (w_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_count <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_work  <= bus.data_i;
            r_count <= bus.shamt_i;
            r_mode  <= bus.arith_i;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_count == '0) begin
            r_data  <= r_work;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_work  <= w_next;
            r_count <= r_count - w_dec;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
  assign bus.data_o = r_data;

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: a timing/result model checked every cycle plus
// directed operations with literal results and busy times.
module tb_shift_right_seq;

`ifdef SHIFT_RIGHT_FAST4_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  shift_right_seq_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

  shift_right_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from the shift definition: arithmetic on a negative value is the
  // complement of the logical shift of its complement.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input bit a);
    if (a && d[31]) return ~((~d) >> s);
    return d >> s;
  endfunction

  function automatic int busy_len(input int s);
    if (FAST) return s / 4 + s % 4 + 2;
    return s + 2;
  endfunction

  // Model: remaining busy cycles, pending result and visible result.
  int          m_left;
  logic [31:0] m_res;
  logic [31:0] m_data;
  bit          m_valid;

  initial begin
    m_left  = 0;
    m_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_left  <= 0;
      m_data  <= 32'h0;
      m_valid <= 1'b1;
    end else if (m_left == 0) begin
      if (bus.start_i) begin
        m_left <= busy_len(int'(bus.shamt_i));
        m_res  <= ref_shift(bus.data_i, int'(bus.shamt_i), bus.arith_i);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_data <= m_res;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", {31'd0, bus.busy_o}, {31'd0, m_left != 0});
      check("model_done", {31'd0, bus.done_o}, {31'd0, m_left == 1});
      check("model_data", bus.data_o, m_data);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic drive_start(input logic [31:0] d, input int s, input bit a);
    bus.data_i  = d;
    bus.shamt_i = s[4:0];
    bus.arith_i = a;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.data_i  = $urandom;
    bus.shamt_i = 5'($urandom);
    bus.arith_i = 1'($urandom);
  endtask

  // Returns the busy cycle count at which done_o was seen (0 if never).
  task automatic wait_done(output int n_out);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.done_o === 1'b1) seen = 1'b1;
    end
    n_out = seen ? n : 0;
  endtask

  task automatic run_op(input string nm, input logic [31:0] d, input int s, input bit a,
                        input logic [31:0] exp_d, input int exp_lat);
    int n;
    wait_idle();
    drive_start(d, s, a);
    wait_done(n);
    check({nm, "_lat"}, n, exp_lat);
    check({nm, "_data"}, bus.data_o, exp_d);
  endtask

  initial begin
    int n;
    int dones;
    logic [31:0] d;
    bit a;
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start_i = 1'b0;
    bus.arith_i = 1'b0;
    bus.data_i  = 32'h0;
    bus.shamt_i = 5'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_data", bus.data_o, 32'h0);
    reset = 1'b1;

    run_op("zero_after_rst", 32'h0000_0000, 0, 1'b0, 32'h0000_0000, 2);
    run_op("srl4",  32'hF000_0000, 4,  1'b0, 32'h0F00_0000, FAST ? 3 : 6);
    run_op("sra31", 32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, FAST ? 12 : 33);
    run_op("srl31", 32'h8000_0000, 31, 1'b0, 32'h0000_0001, FAST ? 12 : 33);
    run_op("sh0",   32'h1234_5678, 0,  1'b1, 32'h1234_5678, 2);
    run_op("sra_pos", 32'h7000_0001, 3, 1'b1, 32'h0E00_0000, FAST ? 5 : 5);

    // Starts during SHIFT and during DONE must be dropped.
    wait_idle();
    drive_start(32'hA5A5_0000, 8, 1'b1);
    @(negedge clk);
    bus.data_i  = 32'hFFFF_FFFF;
    bus.shamt_i = 5'd1;
    bus.arith_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    wait_done(n);
    check("ign_lat", n + 1, FAST ? 4 : 10);
    check("ign_data", bus.data_o, 32'hFFA5_A500);
    bus.data_i  = 32'h0000_00FF;
    bus.shamt_i = 5'd2;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) dones++;
    end
    check("ign_no_done", dones, 0);
    check("ign_hold", bus.data_o, 32'hFFA5_A500);
    check("ign_idle", {31'd0, bus.busy_o}, 32'd0);

    // Reset in the middle of a long operation.
    wait_idle();
    drive_start(32'h1357_9BDF, 20, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done_o}, 32'd0);
    check("mid_rst_data", bus.data_o, 32'h0);
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    run_op("after_rst", 32'hFFFF_0000, 16, 1'b1, 32'hFFFF_FFFF, FAST ? 6 : 18);

    // Every shift amount with random operands and both modes.
    for (int s = 0; s < 32; s++) begin
      d = $urandom;
      a = 1'($urandom_range(0, 1));
      if (s % 8 == 0) d[31] = 1'b1;
      run_op("sweep", d, s, a, ref_shift(d, s, a), busy_len(s));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multi-cycle right shifter for the MIPS ALU datapath: the right-direction counterpart of the processor's fixed left shifter. Executes SRL/SRA/SRLV/SRAV by shifting a captured operand one position per clock under a start/done handshake, so the ALU needs no 32-bit barrel shifter. The block sits beside the ALU. The control unit stalls the pipeline while `busy_o` is high.

## Interface
- `DATA_WIDTH`, 32, operand and result width.
- `SHAMT_WIDTH`, 5, shift-amount width; must equal log2(DATA_WIDTH).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge.
- `start_i` input 1: request a shift; sampled only in IDLE.
- `arith_i` input 1: 1 = arithmetic (sign fill, SRA/SRAV); 0 = logical (zero fill).
- `data_i` input DATA_WIDTH: operand (rt), captured on acceptance.
- `shamt_i` input SHAMT_WIDTH: shift amount, unsigned 0..31, captured on acceptance.
- `busy_o` output 1: high from the acceptance edge until the block returns to IDLE.
- `done_o` output 1: one-cycle pulse; `data_o` is valid in that cycle.
- `data_o` output DATA_WIDTH: registered result; holds its value until the next DONE.

## Operation
- States:
  - IDLE: `busy_o`=0. On `start_i`=1, capture `data_i`, `shamt_i` and `arith_i` into the working register, count and mode, then go to SHIFT.
  - SHIFT: if count==0, copy the working register to `data_o` and go to DONE. Otherwise shift the working register right by 1, fill the MSB with (mode ? current MSB : 0), decrement count, and stay in SHIFT.
  - DONE: `done_o`=1, `busy_o`=1. Go to IDLE on the next edge unconditionally.
- `start_i` is ignored in SHIFT and DONE. There is no queueing. A start in the DONE cycle is lost; the requester re-asserts it in IDLE.
- Input changes after acceptance have no effect.
- shamt=0: result equals the operand; the block still passes through SHIFT once and DONE once.
- shamt=31, logical: result is the original bit 31 in bit 0, all other bits 0.
- shamt=31, arithmetic: all 32 result bits equal the original bit 31.
- Count is SHAMT_WIDTH bits and decrements only while nonzero. It never wraps.
- Reset (`reset`=0 at an edge), including mid-operation:
  - state becomes IDLE;
  - `busy_o`=0, `done_o`=0, `data_o`=0;
  - working register and count are cleared;
  - the aborted operation produces no `done_o`.

## Timing
- Acceptance edge A: the edge at which `start_i`=1 is sampled in IDLE. `busy_o` rises after A.
- Baseline build: `done_o` is high during the cycle after edge A+shamt+1. Busy time is shamt+2 cycles: shamt+1 in SHIFT plus 1 in DONE.
- Back-to-back: the earliest next acceptance is the edge that ends DONE + 1. One IDLE cycle always separates operations.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `SHIFT_RIGHT_FAST4_EN`.
- Defined: each SHIFT cycle shifts by 4 when count≥4, otherwise by 1, using the same fill rule. Busy time becomes floor(shamt/4)+(shamt mod 4)+2. Example: shamt=31 takes 12 cycles.
- Undefined: shift by 1 per cycle only. Results are bit-identical in both builds; only latency differs.

## Structure
- Shared package `mips_shift_pkg`:
  - state encoding constants IDLE/SHIFT/DONE;
  - `DATA_WIDTH`/`SHAMT_WIDTH` defaults;
  - fast-mode step size constant (4).
- Sub-module `shift_right_step`: combinational step with inputs value, mode and step (1 or 4), producing the shifted value with fill. It is instantiated once.
- The top level holds the FSM, count and result registers.

## Test plan
- Logical SRL: reset, then start with data=0xF000_0000, shamt=4, arith=0 → `done_o` after 6 busy cycles (baseline), `data_o`=0x0F00_0000.
- Arithmetic SRA: data=0x8000_0000, shamt=31, arith=1 → `data_o`=0xFFFF_FFFF. Repeat with arith=0 → `data_o`=0x0000_0001.
- Zero shift: data=0x1234_5678, shamt=0 → `data_o`=0x1234_5678, `done_o` pulse exactly 2 cycles after acceptance. Also start with shamt=0 and data=0 immediately after reset → `data_o`=0.
- Start ignored: pulse `start_i` with a new operand during SHIFT and during DONE → no second `done_o`; first result unchanged. `data_o` holds until the next DONE.
- Reset mid-op: start with shamt=20; drive `reset`=0 for one edge at cycle 5 → `busy_o`=0, `data_o`=0, no `done_o`. A new start with 0xFFFF_0000, shamt=16, arith=1 → 0xFFFF_FFFF.
- `SHIFT_RIGHT_FAST4_EN` build: data=0x8000_0000, shamt=31, arith=0 → `data_o`=0x0000_0001 in 12 busy cycles; results match the baseline for random operands and all 32 shamt values.
